// File: rtl/bcd_mod_counter.sv
// Two-digit BCD timer/counter stage with a debounced start/pause key,
// up/down counting, synchronous clear/load, a wrap carry pulse for cascading
// and two seven-segment digit outputs. Runs on the board clock only; the
// count advances on a one-cycle enable, either from the internal prescaler
// or from a neighbour stage's carry.
//
// Run/pause FSM states:
//   state      | meaning
//   -----------+-------------------------------------------------
//   ST_PAUSED  | count and prescaler frozen, ones-digit DP off
//   ST_RUNNING | prescaler/ext_tick advance the count, DP on
module bcd_mod_counter #(
  parameter int CLK_HZ       = 12_000_000,
  parameter int TICK_HZ      = 1,
  parameter int MODULUS      = 60,
  parameter int DEB_CYCLES   = 240_000,
  parameter int USE_EXT_TICK = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  input  logic       dir_up,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       ext_tick,
  output logic [7:0] cnt_bcd,
  output logic       running,
  output logic       carry,
  output logic [8:0] segment_led_1,
  output logic [8:0] segment_led_2
);

  localparam int PERIOD = CLK_HZ / TICK_HZ;
  localparam int PRE_W  = $clog2(PERIOD);
  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PERIOD - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  // Largest count value (MODULUS-1) split into BCD digits.
  localparam logic [3:0] MAX_TENS = 4'((MODULUS - 1) / 10);
  localparam logic [3:0] MAX_ONES = 4'((MODULUS - 1) % 10);
  localparam logic [7:0] MAX_BCD  = {MAX_TENS, MAX_ONES};

  typedef enum logic {
    ST_PAUSED  = 1'b0,
    ST_RUNNING = 1'b1
  } run_state_t;

  run_state_t state, state_nxt;

  logic             key_s1, key_s2;
  logic             key_deb, key_deb_q;
  logic [DEB_W-1:0] deb_cnt;
  logic             key_press;

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic             adv;

  logic [3:0] tens, ones;
  logic [3:0] tens_nxt, ones_nxt;
  logic       wrap;
  logic       load_ok;

  // Two-flop synchroniser for the asynchronous, active-low key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
    end
  end

  // Debouncer: adopt the synchronised level only after it has differed from
  // the current debounced level for DEB_CYCLES consecutive samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_deb   <= 1'b1;
      key_deb_q <= 1'b1;
      deb_cnt   <= '0;
    end else begin
      key_deb_q <= key_deb;
      if (key_s2 == key_deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        key_deb <= key_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // A press is a debounced high-to-low transition; a held key yields one.
  assign key_press = key_deb_q & ~key_deb;

  // Run/pause state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_PAUSED;
    end else begin
      state <= state_nxt;
    end
  end

  // Run/pause next state: every press toggles.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_PAUSED:  if (key_press) state_nxt = ST_RUNNING;
      ST_RUNNING: if (key_press) state_nxt = ST_PAUSED;
      default:    state_nxt = ST_PAUSED;
    endcase
  end

  assign running = (state == ST_RUNNING);

  // Prescaler: free-runs while running, holds while paused so a resume keeps
  // the fraction of the period already elapsed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (clr) begin
      pre_cnt <= '0;
    end else if (running) begin
      if (pre_cnt == PRE_LAST) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end
    end
  end

  assign tick = running & (pre_cnt == PRE_LAST);
  assign adv  = running & ((USE_EXT_TICK != 0) ? ext_tick : tick);

  // A load value is accepted only if it is valid BCD and below MODULUS; with
  // valid digits the BCD compare orders the same as the decimal value.
  assign load_ok = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9) &&
                   (load_val <= MAX_BCD);

  // Next count, priority clr > load > adv; wrap flags the modulus rollover.
  always_comb begin
    tens_nxt = tens;
    ones_nxt = ones;
    wrap     = 1'b0;
    if (clr) begin
      tens_nxt = 4'd0;
      ones_nxt = 4'd0;
    end else if (load) begin
      if (load_ok) begin
        tens_nxt = load_val[7:4];
        ones_nxt = load_val[3:0];
      end
    end else if (adv) begin
      if (dir_up) begin
        if ((tens == MAX_TENS) && (ones == MAX_ONES)) begin
          tens_nxt = 4'd0;
          ones_nxt = 4'd0;
          wrap     = 1'b1;
        end else if (ones == 4'd9) begin
          ones_nxt = 4'd0;
          tens_nxt = tens + 4'd1;
        end else begin
          ones_nxt = ones + 4'd1;
        end
      end else begin
        if ((tens == 4'd0) && (ones == 4'd0)) begin
          tens_nxt = MAX_TENS;
          ones_nxt = MAX_ONES;
          wrap     = 1'b1;
        end else if (ones == 4'd0) begin
          ones_nxt = 4'd9;
          tens_nxt = tens - 4'd1;
        end else begin
          ones_nxt = ones - 4'd1;
        end
      end
    end
  end

  // Count and carry registers; carry marks the cycle the wrapped value shows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens  <= 4'd0;
      ones  <= 4'd0;
      carry <= 1'b0;
    end else begin
      tens  <= tens_nxt;
      ones  <= ones_nxt;
      carry <= wrap;
    end
  end

  assign cnt_bcd = {tens, ones};

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3f;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5b;
      4'd3:    seg7 = 7'h4f;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6d;
      4'd6:    seg7 = 7'h7d;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7f;
      4'd9:    seg7 = 7'h6f;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Bit order SEG,DP,G..A; the ones-digit DP doubles as the run indicator.
  assign segment_led_1 = {1'b0, 1'b0, seg7(tens)};
  assign segment_led_2 = {1'b0, running, seg7(ones)};

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: instance A uses the internal prescaler
// (MODULUS=60), instance B counts ext_tick pulses (MODULUS=100).
module tb_bcd_mod_counter;

  localparam logic [6:0] SEG_TAB [10] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66,
                                          7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};

  typedef struct {
    logic       clr;
    logic       load;
    logic [7:0] lv;
    logic       dir;
    logic [7:0] exp_cnt;
    logic       exp_carry;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a_key = 1'b1, a_dir = 1'b1, a_clr = 1'b0, a_load = 1'b0, a_ext = 1'b0;
  logic [7:0] a_lv = 8'h00;
  logic [7:0] a_cnt;
  logic       a_run, a_carry;
  logic [8:0] a_s1, a_s2;

  logic       b_key = 1'b1, b_dir = 1'b1, b_clr = 1'b0, b_load = 1'b0, b_ext = 1'b0;
  logic [7:0] b_lv = 8'h00;
  logic [7:0] b_cnt;
  logic       b_run, b_carry;
  logic [8:0] b_s1, b_s2;

  int n_cmp = 0;
  int n_mis = 0;

  vec_t vecs [10];

  always #5 clk = ~clk;

  bcd_mod_counter #(.CLK_HZ(10), .TICK_HZ(1), .MODULUS(60), .DEB_CYCLES(4),
                    .USE_EXT_TICK(0)) dut_a (
    .clk(clk), .rst(rst), .key(a_key), .dir_up(a_dir), .clr(a_clr),
    .load(a_load), .load_val(a_lv), .ext_tick(a_ext), .cnt_bcd(a_cnt),
    .running(a_run), .carry(a_carry), .segment_led_1(a_s1), .segment_led_2(a_s2));

  bcd_mod_counter #(.CLK_HZ(10), .TICK_HZ(1), .MODULUS(100), .DEB_CYCLES(4),
                    .USE_EXT_TICK(1)) dut_b (
    .clk(clk), .rst(rst), .key(b_key), .dir_up(b_dir), .clr(b_clr),
    .load(b_load), .load_val(b_lv), .ext_tick(b_ext), .cnt_bcd(b_cnt),
    .running(b_run), .carry(b_carry), .segment_led_1(b_s1), .segment_led_2(b_s2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [8:0] exp_seg1(input int v);
    return {2'b00, SEG_TAB[v / 10]};
  endfunction

  function automatic logic [8:0] exp_seg2(input int v, input logic run);
    return {1'b0, run, SEG_TAB[v % 10]};
  endfunction

  function automatic bit bcd_ok(input logic [7:0] lv, input int modulus);
    int t, o;
    t = int'(lv[7:4]);
    o = int'(lv[3:0]);
    return (t <= 9) && (o <= 9) && ((t * 10 + o) < modulus);
  endfunction

  // Reference count update from the counting rules, in plain decimal.
  task automatic model_step(input int modulus, input logic clr_i, input logic load_i,
                            input logic [7:0] lv_i, input logic dir_i, input logic adv_i,
                            inout int v, output logic c);
    c = 1'b0;
    if (clr_i) begin
      v = 0;
    end else if (load_i) begin
      if (bcd_ok(lv_i, modulus)) v = int'(lv_i[7:4]) * 10 + int'(lv_i[3:0]);
    end else if (adv_i) begin
      if (dir_i) begin
        c = (v == modulus - 1);
        v = (v + 1) % modulus;
      end else begin
        c = (v == 0);
        v = (v + modulus - 1) % modulus;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ma_v, ma_ph, mb_v;
    logic ma_c, mb_c;
    logic r_aclr, r_aload, r_adir, r_bclr, r_bload, r_bdir, r_bext;
    logic [7:0] r_alv, r_blv;

    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h47, 1'b1, 8'h47, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h6A, 1'b1, 8'h47, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'h60, 1'b1, 8'h47, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'h59, 1'b0, 8'h59, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'hA0, 1'b1, 8'h59, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 8'h47, 1'b1, 8'h00, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 8'h09, 1'b1, 8'h09, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0};

    // Reset held from time zero, checked before the first clock edge.
    #2;
    chk("rst_a_cnt", a_cnt, 8'h00);
    chk("rst_a_run", a_run, 1'b0);
    chk("rst_a_carry", a_carry, 1'b0);
    chk("rst_a_seg1", a_s1, 9'h03f);
    chk("rst_a_seg2", a_s2, 9'h03f);
    chk("rst_b_cnt", b_cnt, 8'h00);
    chk("rst_b_seg2", b_s2, 9'h03f);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("idle_a_cnt", a_cnt, 8'h00);

    // Up count: key latency is 2 + DEB_CYCLES + 1 edges.
    @(negedge clk) a_key = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("press_lat_early", a_run, 1'b0);
    @(posedge clk);
    #1 chk("press_lat_run", a_run, 1'b1);
    chk("press_dp", a_s2, 9'h0bf);
    @(posedge clk);
    @(negedge clk) a_key = 1'b1;
    repeat (588) @(posedge clk);
    #1 chk("up_589", a_cnt, 8'h58);
    @(posedge clk);
    #1 chk("up_590", a_cnt, 8'h59);
    chk("up_590_carry", a_carry, 1'b0);
    repeat (9) @(posedge clk);
    #1 chk("up_599", a_cnt, 8'h59);
    @(posedge clk);
    #1 chk("up_wrap", a_cnt, 8'h00);
    chk("up_wrap_carry", a_carry, 1'b1);
    @(posedge clk);
    #1 chk("up_carry_1cyc", a_carry, 1'b0);

    // Down count from a load of 00.
    @(negedge clk) begin a_clr = 1'b1; a_dir = 1'b0; end
    @(posedge clk);
    #1 chk("dn_clr", a_cnt, 8'h00);
    @(negedge clk) begin a_clr = 1'b0; a_load = 1'b1; a_lv = 8'h00; end
    @(posedge clk);
    #1 chk("dn_load00", a_cnt, 8'h00);
    @(negedge clk) a_load = 1'b0;
    repeat (8) @(posedge clk);
    #1 chk("dn_before", a_cnt, 8'h00);
    chk("dn_before_carry", a_carry, 1'b0);
    @(posedge clk);
    #1 chk("dn_wrap", a_cnt, 8'h59);
    chk("dn_wrap_carry", a_carry, 1'b1);
    @(posedge clk);
    #1 chk("dn_carry_1cyc", a_carry, 1'b0);
    repeat (9) @(posedge clk);
    #1 chk("dn_58", a_cnt, 8'h58);

    // Debounce: 3-cycle glitch, 20-cycle hold, paused prescaler preserved.
    @(negedge clk) a_clr = 1'b1;
    @(posedge clk);
    #1 chk("deb_clr_cnt", a_cnt, 8'h00);
    chk("deb_clr_run", a_run, 1'b1);
    @(negedge clk) begin a_clr = 1'b0; a_key = 1'b0; end
    repeat (3) @(negedge clk);
    a_key = 1'b1;
    repeat (7) @(negedge clk);
    chk("glitch_no_toggle", a_run, 1'b1);
    a_key = 1'b0;
    repeat (20) @(negedge clk);
    a_key = 1'b1;
    chk("hold_toggle", a_run, 1'b0);
    repeat (12) @(negedge clk);
    chk("hold_one_toggle", a_run, 1'b0);
    chk("pause_cnt", a_cnt, 8'h59);
    chk("pause_seg1", a_s1, 9'h06d);
    chk("pause_seg2", a_s2, 9'h06f);
    a_key = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("resume_early", a_run, 1'b0);
    @(posedge clk);
    #1 chk("resume_run", a_run, 1'b1);
    chk("resume_cnt", a_cnt, 8'h59);
    repeat (2) @(posedge clk);
    #1 chk("resume_pre_hold", a_cnt, 8'h59);
    @(posedge clk);
    #1 chk("resume_pre_kept", a_cnt, 8'h58);
    chk("resume_no_carry", a_carry, 1'b0);
    @(negedge clk) a_key = 1'b1;
    repeat (10) @(negedge clk);

    // Load/clear vectors, applied within one prescaler period after a clear.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) begin
        a_clr = vecs[i].clr; a_load = vecs[i].load;
        a_lv = vecs[i].lv; a_dir = vecs[i].dir;
      end
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_cnt", i), a_cnt, vecs[i].exp_cnt);
      chk($sformatf("vec%0d_carry", i), a_carry, vecs[i].exp_carry);
    end
    @(negedge clk) begin a_clr = 1'b0; a_load = 1'b0; a_dir = 1'b1; end

    // Instance B: external tick, MODULUS=100.
    @(negedge clk) b_key = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("b_press", b_run, 1'b1);
    @(negedge clk) b_key = 1'b1;
    repeat (10) @(negedge clk);
    b_clr = 1'b1;
    @(negedge clk) b_clr = 1'b0;
    for (int i = 0; i < 99; i++) begin
      @(negedge clk) b_ext = 1'b1;
      @(negedge clk) b_ext = 1'b0;
    end
    chk("b_99", b_cnt, 8'h99);
    chk("b_99_carry", b_carry, 1'b0);
    chk("b_99_seg1", b_s1, 9'h06f);
    chk("b_99_seg2", b_s2, 9'h0ef);
    @(negedge clk) b_ext = 1'b1;
    @(posedge clk);
    #1 chk("b_100", b_cnt, 8'h00);
    chk("b_100_carry", b_carry, 1'b1);
    @(negedge clk) b_ext = 1'b0;
    @(posedge clk);
    #1 chk("b_carry_1cyc", b_carry, 1'b0);
    @(negedge clk) begin b_dir = 1'b0; b_ext = 1'b1; end
    @(posedge clk);
    #1 chk("b_dn_wrap", b_cnt, 8'h99);
    chk("b_dn_carry", b_carry, 1'b1);
    @(negedge clk) begin b_dir = 1'b1; b_load = 1'b1; b_lv = 8'h99; end
    @(posedge clk);
    #1 chk("b_load_wins", b_cnt, 8'h99);
    chk("b_load_no_carry", b_carry, 1'b0);
    @(negedge clk) begin b_load = 1'b0; b_ext = 1'b0; end

    // Randomised traffic on both instances against the decimal model.
    ma_v = 0; ma_ph = 0; mb_v = 0;
    for (int i = 0; i < 2000; i++) begin
      r_aclr  = (i == 0) || ($urandom_range(0, 31) == 0);
      r_aload = ($urandom_range(0, 9) == 0);
      r_alv   = $urandom_range(0, 1) ? 8'($urandom_range(0, 255)) : to_bcd(int'($urandom_range(0, 99)));
      r_adir  = ($urandom_range(0, 19) == 0) ? ~a_dir : a_dir;
      r_bclr  = (i == 0) || ($urandom_range(0, 31) == 0);
      r_bload = ($urandom_range(0, 9) == 0);
      r_blv   = $urandom_range(0, 1) ? 8'($urandom_range(0, 255)) : to_bcd(int'($urandom_range(0, 99)));
      r_bdir  = ($urandom_range(0, 19) == 0) ? ~b_dir : b_dir;
      r_bext  = 1'($urandom_range(0, 1));
      @(negedge clk) begin
        a_clr = r_aclr; a_load = r_aload; a_lv = r_alv; a_dir = r_adir;
        b_clr = r_bclr; b_load = r_bload; b_lv = r_blv; b_dir = r_bdir; b_ext = r_bext;
      end
      @(posedge clk);
      #1;
      model_step(60, r_aclr, r_aload, r_alv, r_adir, (ma_ph == 9), ma_v, ma_c);
      ma_ph = r_aclr ? 0 : (ma_ph + 1) % 10;
      model_step(100, r_bclr, r_bload, r_blv, r_bdir, r_bext, mb_v, mb_c);
      chk("rnd_a_cnt", a_cnt, to_bcd(ma_v));
      chk("rnd_a_carry", a_carry, ma_c);
      chk("rnd_a_seg1", a_s1, exp_seg1(ma_v));
      chk("rnd_a_seg2", a_s2, exp_seg2(ma_v, 1'b1));
      chk("rnd_b_cnt", b_cnt, to_bcd(mb_v));
      chk("rnd_b_carry", b_carry, mb_c);
      chk("rnd_b_seg2", b_s2, exp_seg2(mb_v, 1'b1));
    end
    @(negedge clk) begin
      a_clr = 1'b0; a_load = 1'b0; b_clr = 1'b0; b_load = 1'b0; b_ext = 1'b0;
    end

    // Pause B; ext_tick must then have no effect.
    @(negedge clk) b_key = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("b_pause", b_run, 1'b0);
    @(negedge clk) b_key = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) b_ext = 1'b1;
      @(negedge clk) b_ext = 1'b0;
    end
    chk("b_paused_cnt", b_cnt, to_bcd(mb_v));
    chk("b_paused_carry", b_carry, 1'b0);
    chk("b_paused_dp", b_s2, exp_seg2(mb_v, 1'b0));

    // Asynchronous reset in the middle of a clock phase.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_a_cnt", a_cnt, 8'h00);
    chk("arst_a_run", a_run, 1'b0);
    chk("arst_a_carry", a_carry, 1'b0);
    chk("arst_a_seg1", a_s1, 9'h03f);
    chk("arst_a_seg2", a_s2, 9'h03f);
    chk("arst_b_cnt", b_cnt, 8'h00);
    chk("arst_b_seg1", b_s1, 9'h03f);
    @(negedge clk) rst = 1'b0;
    repeat (15) @(posedge clk);
    #1 chk("post_rst_a_cnt", a_cnt, 8'h00);
    chk("post_rst_a_run", a_run, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
